// File: rtl/vscale_sys_uart.sv
// System-bus UART: memory-mapped TX FIFO, shifter and baud divisor.
// The receiver is built only when VSCALE_UART_RX_EN is defined.
`ifndef HASTI_ADDR_WIDTH
`define HASTI_ADDR_WIDTH 32
`endif
`ifndef HASTI_SIZE_WIDTH
`define HASTI_SIZE_WIDTH 3
`endif
`ifndef HASTI_BUS_WIDTH
`define HASTI_BUS_WIDTH 32
`endif

module vscale_sys_uart #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd867
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ss_sel,
  input  logic                         ss_read,
  input  logic                         ss_write,
  input  logic [`HASTI_ADDR_WIDTH-1:0] ss_addr,
  input  logic [`HASTI_SIZE_WIDTH-1:0] ss_size,
  input  logic [`HASTI_BUS_WIDTH-1:0]  ss_wdata,
  output logic [`HASTI_BUS_WIDTH-1:0]  ss_rdata,
  output logic                         ss_ready,
  output logic                         ss_resp,
  output logic                         txd,
  input  logic                         rxd,
  output logic                         irq
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned BW = `HASTI_BUS_WIDTH;
  localparam logic [1:0] A_TX = 2'd0, A_RX = 2'd1, A_ST = 2'd2, A_DIV = 2'd3;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  logic          dp_valid, dp_write;
  logic [1:0]    dp_addr;
  logic [15:0]   div;
  logic          irq_en_rx;
  logic [7:0]    fifo [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          fifo_empty, fifo_full, push, pop;
  logic          tx_wr, div_wr, rx_rd, accept, tx_empty;
  logic          rx_valid, rx_ferr;
  logic [7:0]    rx_byte;

  tx_state_t     tx_state, tx_state_nxt;
  logic [7:0]    tx_shift, tx_shift_nxt;
  logic [2:0]    tx_bit, tx_bit_nxt;
  logic [15:0]   tx_cnt, tx_cnt_nxt, tx_div, tx_div_nxt;
  logic          txd_nxt, tx_bit_done;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // Data-phase decode; a TXDATA write into a full FIFO waits unless a pop frees a slot this cycle.
  assign tx_wr    = dp_valid && dp_write && (dp_addr == A_TX);
  assign div_wr   = dp_valid && dp_write && (dp_addr == A_DIV);
  assign rx_rd    = dp_valid && !dp_write && (dp_addr == A_RX) && rx_valid;
  assign push     = tx_wr && (!fifo_full || pop);
  assign ss_ready = !(tx_wr && fifo_full && !pop);
  assign ss_resp  = 1'b0;
  assign accept   = ss_sel && (ss_read || ss_write) && ss_ready;
  assign tx_empty = fifo_empty && (tx_state == TX_IDLE);
  assign irq      = tx_empty || (irq_en_rx && rx_valid);

  always_comb begin
    ss_rdata = '0;
    if (dp_valid && !dp_write) begin
      unique case (dp_addr)
        A_RX:    ss_rdata = BW'({~rx_valid, 23'b0, rx_byte});
        A_ST:    ss_rdata = BW'({irq_en_rx, rx_ferr, rx_valid, tx_empty, fifo_full});
        A_DIV:   ss_rdata = BW'({irq_en_rx, div});
        default: ss_rdata = '0;
      endcase
    end
  end

  // Bus phase tracking, control registers and FIFO pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dp_valid  <= 1'b0;
      dp_write  <= 1'b0;
      dp_addr   <= '0;
      div       <= DIV_RESET;
      irq_en_rx <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      if (ss_ready) begin
        dp_valid <= accept;
        dp_write <= ss_write;
        dp_addr  <= ss_addr[3:2];
      end
      if (div_wr) begin
        div       <= ss_wdata[15:0];
        irq_en_rx <= ss_wdata[16];
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr[AW-1:0]] <= ss_wdata[7:0];
  end

  assign tx_bit_done = (tx_cnt == tx_div);

  // TX next state; the divisor is latched per frame so DIV writes apply at the next start bit.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_shift_nxt = tx_shift;
    tx_bit_nxt   = tx_bit;
    tx_cnt_nxt   = tx_cnt + 16'd1;
    tx_div_nxt   = tx_div;
    txd_nxt      = txd;
    pop          = 1'b0;
    unique case (tx_state)
      TX_IDLE: begin
        tx_cnt_nxt = '0;
        if (!fifo_empty) begin
          pop          = 1'b1;
          tx_state_nxt = TX_START;
          tx_shift_nxt = fifo[rd_ptr[AW-1:0]];
          tx_div_nxt   = div;
          txd_nxt      = 1'b0;
        end
      end
      TX_START: begin
        if (tx_bit_done) begin
          tx_cnt_nxt   = '0;
          tx_bit_nxt   = '0;
          tx_state_nxt = TX_DATA;
          txd_nxt      = tx_shift[0];
        end
      end
      TX_DATA: begin
        if (tx_bit_done) begin
          tx_cnt_nxt   = '0;
          tx_bit_nxt   = tx_bit + 3'd1;
          tx_shift_nxt = {1'b0, tx_shift[7:1]};
          txd_nxt      = tx_shift[1];
          if (tx_bit == 3'd7) begin
            tx_state_nxt = TX_STOP;
            txd_nxt      = 1'b1;
          end
        end
      end
      TX_STOP: begin
        if (tx_bit_done) begin
          tx_cnt_nxt   = '0;
          tx_state_nxt = TX_IDLE;
          if (!fifo_empty) begin
            pop          = 1'b1;
            tx_state_nxt = TX_START;
            tx_shift_nxt = fifo[rd_ptr[AW-1:0]];
            tx_div_nxt   = div;
            txd_nxt      = 1'b0;
          end
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_shift <= '0;
      tx_bit   <= '0;
      tx_cnt   <= '0;
      tx_div   <= '0;
      txd      <= 1'b1;
    end else begin
      tx_state <= tx_state_nxt;
      tx_shift <= tx_shift_nxt;
      tx_bit   <= tx_bit_nxt;
      tx_cnt   <= tx_cnt_nxt;
      tx_div   <= tx_div_nxt;
      txd      <= txd_nxt;
    end
  end

`ifdef VSCALE_UART_RX_EN
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t   rx_state, rx_state_nxt;
  logic        rx_s1, rx_s2, rx_prev, rx_done;
  logic [15:0] rx_cnt, rx_cnt_nxt, rx_div, rx_div_nxt, rx_half;
  logic [7:0]  rx_shift, rx_shift_nxt;
  logic [2:0]  rx_bit, rx_bit_nxt;

  assign rx_half = 16'((17'(rx_div) + 17'd1) >> 1);

  // Falling-edge start detect counts as cycle 0 of the start bit; sampling then lands mid-bit.
  always_comb begin
    rx_state_nxt = rx_state;
    rx_cnt_nxt   = rx_cnt + 16'd1;
    rx_div_nxt   = rx_div;
    rx_shift_nxt = rx_shift;
    rx_bit_nxt   = rx_bit;
    rx_done      = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        rx_cnt_nxt = '0;
        rx_bit_nxt = '0;
        if (rx_prev && !rx_s2) begin
          rx_div_nxt = div;
          if (div == 16'd0) begin
            rx_state_nxt = RX_DATA;
          end else begin
            rx_state_nxt = RX_START;
            rx_cnt_nxt   = 16'd1;
          end
        end
      end
      RX_START: begin
        if (rx_cnt == rx_half) begin
          rx_cnt_nxt   = '0;
          rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == rx_div) begin
          rx_cnt_nxt   = '0;
          rx_shift_nxt = {rx_s2, rx_shift[7:1]};
          rx_bit_nxt   = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt == rx_div) begin
          rx_done      = 1'b1;
          rx_state_nxt = RX_IDLE;
        end
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_div   <= '0;
      rx_shift <= '0;
      rx_bit   <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_s1    <= rxd;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_state <= rx_state_nxt;
      rx_cnt   <= rx_cnt_nxt;
      rx_div   <= rx_div_nxt;
      rx_shift <= rx_shift_nxt;
      rx_bit   <= rx_bit_nxt;
      if (rx_done) begin
        rx_byte  <= rx_shift;
        rx_valid <= 1'b1;
        rx_ferr  <= !rx_s2;
      end else if (rx_rd) begin
        rx_valid <= 1'b0;
        rx_ferr  <= 1'b0;
      end
    end
  end

  logic unused_rx;
  assign unused_rx = 1'b0;
`else
  assign rx_valid = 1'b0;
  assign rx_ferr  = 1'b0;
  assign rx_byte  = '0;

  logic unused_rx;
  assign unused_rx = ^{rxd, rx_rd};
`endif

  logic unused_bus;
  assign unused_bus = ^{ss_size, ss_addr[`HASTI_ADDR_WIDTH-1:4], ss_addr[1:0],
                        ss_wdata[`HASTI_BUS_WIDTH-1:17], unused_rx};

endmodule

// File: tb/tb_vscale_sys_uart.sv
// Directed bench for vscale_sys_uart: register table, TX framing, FIFO stall, reset, optional RX.
`ifndef HASTI_ADDR_WIDTH
`define HASTI_ADDR_WIDTH 32
`endif
`ifndef HASTI_SIZE_WIDTH
`define HASTI_SIZE_WIDTH 3
`endif
`ifndef HASTI_BUS_WIDTH
`define HASTI_BUS_WIDTH 32
`endif

module tb_vscale_sys_uart;

  logic                         clk = 1'b0;
  logic                         reset;
  logic                         ss_sel, ss_read, ss_write;
  logic [`HASTI_ADDR_WIDTH-1:0] ss_addr;
  logic [`HASTI_SIZE_WIDTH-1:0] ss_size;
  logic [`HASTI_BUS_WIDTH-1:0]  ss_wdata;
  logic [`HASTI_BUS_WIDTH-1:0]  ss_rdata;
  logic                         ss_ready, ss_resp, txd, rxd, irq;
  logic                         loop_en = 1'b0;
  logic                         rxd_drv = 1'b1;
  logic                         rec_en = 1'b0;
  logic                         rec_q[$];

  int total = 0;
  int bad   = 0;

  vscale_sys_uart #(.FIFO_DEPTH(8), .DIV_RESET(16'd867)) dut (
    .clk(clk), .reset(reset),
    .ss_sel(ss_sel), .ss_read(ss_read), .ss_write(ss_write),
    .ss_addr(ss_addr), .ss_size(ss_size), .ss_wdata(ss_wdata),
    .ss_rdata(ss_rdata), .ss_ready(ss_ready), .ss_resp(ss_resp),
    .txd(txd), .rxd(rxd), .irq(irq)
  );

  always #5 clk = ~clk;
  assign rxd = loop_en ? txd : rxd_drv;

  always @(negedge clk) if (rec_en) rec_q.push_back(txd);

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!ss_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!ss_ready) begin
      total++;
      bad++;
      $display("FAIL %s: ss_ready still 0 after %0d cycles, expected 1", name, n);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    ss_sel = 1'b1; ss_write = 1'b1; ss_read = 1'b0; ss_addr = a;
    @(negedge clk);
    ss_sel = 1'b0; ss_write = 1'b0; ss_wdata = d;
    wait_ready("write_ready");
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    ss_sel = 1'b1; ss_read = 1'b1; ss_write = 1'b0; ss_addr = a;
    @(negedge clk);
    ss_sel = 1'b0; ss_read = 1'b0;
    wait_ready("read_ready");
    d = ss_rdata;
  endtask

  function automatic int first_zero();
    for (int i = 0; i < rec_q.size(); i++) if (rec_q[i] == 1'b0) return i;
    return -1;
  endfunction

  task automatic send_raw(input logic [7:0] b, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd_drv = fr[i];
      repeat (8) @(negedge clk);
    end
    rxd_drv = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [9:0]  fr;
    logic [7:0]  bytes[10];
    int          stall[10];
    int          s, n, zeros;
    logic [3:0]  smp;

    reset = 1'b1; ss_sel = 1'b0; ss_read = 1'b0; ss_write = 1'b0;
    ss_addr = '0; ss_size = '0; ss_wdata = '0;
    #1;
    check("rst_txd",   32'(txd), 32'd1);
    check("rst_ready", 32'(ss_ready), 32'd1);
    check("rst_rdata", ss_rdata, 32'd0);
    check("rst_resp",  32'(ss_resp), 32'd0);
    check("rst_irq",   32'(irq), 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Register map walk: reads are compared, writes just drive state.
    vecs[0]  = '{1'b0, 32'h8,  32'h0,         32'h2};
    vecs[1]  = '{1'b0, 32'hC,  32'h0,         32'h363};
    vecs[2]  = '{1'b1, 32'hC,  32'h0001_0005, 32'h0};
    vecs[3]  = '{1'b0, 32'hC,  32'h0,         32'h0001_0005};
    vecs[4]  = '{1'b0, 32'h8,  32'h0,         32'h12};
    vecs[5]  = '{1'b0, 32'h4,  32'h0,         32'h8000_0000};
    vecs[6]  = '{1'b0, 32'h0,  32'h0,         32'h0};
    vecs[7]  = '{1'b1, 32'h4,  32'hFF,        32'h0};
    vecs[8]  = '{1'b0, 32'h1C, 32'h0,         32'h0001_0005};
    vecs[9]  = '{1'b1, 32'hC,  32'hFFFE_0003, 32'h0};
    vecs[10] = '{1'b0, 32'hC,  32'h0,         32'h0000_0003};
    vecs[11] = '{1'b0, 32'h8,  32'h0,         32'h2};
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data);
      else begin
        bus_read(vecs[i].addr, rd);
        check($sformatf("vec%0d", i), rd, vecs[i].exp);
      end
    end

    // DIV=3: 0x55 framed as 10 bits of 4 cycles each.
    rec_q.delete();
    rec_en = 1'b1;
    bus_write(32'h0, 32'h55);
    repeat (5) @(negedge clk);
    check("tx55_irq_busy", 32'(irq), 32'd0);
    repeat (55) @(negedge clk);
    rec_en = 1'b0;
    fr = {1'b1, 8'h55, 1'b0};
    s = first_zero();
    if (s < 0 || s + 41 > rec_q.size()) begin
      total++; bad++;
      $display("FAIL tx55_frame: start bit at %0d of %0d samples, expected a full frame", s, rec_q.size());
    end else begin
      for (int b = 0; b < 10; b++) begin
        smp = {rec_q[s+4*b], rec_q[s+4*b+1], rec_q[s+4*b+2], rec_q[s+4*b+3]};
        check($sformatf("tx55_bit%0d", b), 32'(smp), 32'({4{fr[b]}}));
      end
      check("tx55_idle_after", 32'(rec_q[s+40]), 32'd1);
    end
    bus_read(32'h8, rd);
    check("tx55_status", rd, 32'h2);
    check("tx55_irq", 32'(irq), 32'd1);

    // DIV=0: ten pipelined writes, the tenth must wait for the first pop out of a full FIFO.
    bus_write(32'hC, 32'h0);
    bytes = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h5A, 8'hA5, 8'h3C, 8'hC3, 8'h7E, 8'h81};
    rec_q.delete();
    rec_en = 1'b1;
    @(negedge clk);
    ss_sel = 1'b1; ss_write = 1'b1; ss_read = 1'b0; ss_addr = 32'h0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ss_wdata = 32'(bytes[i]);
      if (i == 9) begin ss_sel = 1'b0; ss_write = 1'b0; end
      stall[i] = 0;
      while (!ss_ready && stall[i] < 100) begin
        @(negedge clk);
        stall[i]++;
      end
    end
    repeat (115) @(negedge clk);
    rec_en = 1'b0;
    for (int i = 0; i < 9; i++) check($sformatf("b2b_stall%0d", i), 32'(stall[i]), 32'd0);
    check("b2b_stall9_seen", 32'(stall[9] > 0 && stall[9] < 100), 32'd1);
    s = first_zero();
    if (s < 0 || s + 101 > rec_q.size()) begin
      total++; bad++;
      $display("FAIL b2b_frames: start bit at %0d of %0d samples, expected 10 frames", s, rec_q.size());
    end else begin
      for (int k = 0; k < 10; k++) begin
        for (int j = 0; j < 10; j++) fr[j] = rec_q[s+10*k+j];
        check($sformatf("b2b_frame%0d", k), 32'(fr), 32'({1'b1, bytes[k], 1'b0}));
      end
      check("b2b_idle_after", 32'(rec_q[s+100]), 32'd1);
    end

    // Reset in the middle of the data bits of 0xA3.
    bus_write(32'hC, 32'h3);
    bus_write(32'h0, 32'hA3);
    n = 0;
    while (txd !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_started", 32'(txd), 32'd0);
    repeat (12) @(negedge clk);
    check("rst_mid_busy_irq", 32'(irq), 32'd0);
    reset = 1'b1;
    #1;
    check("rst_mid_txd",   32'(txd), 32'd1);
    check("rst_mid_ready", 32'(ss_ready), 32'd1);
    check("rst_mid_irq",   32'(irq), 32'd1);
    check("rst_mid_rdata", ss_rdata, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bus_read(32'h8, rd);
    check("rst_mid_status", rd, 32'h2);
    bus_read(32'hC, rd);
    check("rst_mid_div", rd, 32'h363);
    zeros = 0;
    repeat (30) begin
      @(negedge clk);
      if (txd !== 1'b1) zeros++;
    end
    check("rst_mid_txd_quiet", 32'(zeros), 32'd0);

`ifdef VSCALE_UART_RX_EN
    // Loopback receive with the RX interrupt enabled.
    loop_en = 1'b1;
    bus_write(32'hC, 32'h0001_0007);
    bus_write(32'h0, 32'hC4);
    repeat (120) @(negedge clk);
    bus_read(32'h8, rd);
    check("rx_status", rd, 32'h16);
    check("rx_irq", 32'(irq), 32'd1);
    bus_read(32'h4, rd);
    check("rx_data", rd, 32'h0000_00C4);
    bus_read(32'h4, rd);
    check("rx_data_empty", rd, 32'h8000_0000);
    loop_en = 1'b0;

    // Framing error: stop bit driven low.
    repeat (4) @(negedge clk);
    send_raw(8'h12, 1'b0);
    repeat (20) @(negedge clk);
    bus_read(32'h8, rd);
    check("rx_ferr_status", rd, 32'h1E);
    bus_read(32'h4, rd);
    check("rx_ferr_data", rd, 32'h0000_0012);
    bus_read(32'h8, rd);
    check("rx_ferr_cleared", rd, 32'h12);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
